onehot_decoder_seq: RTL
=======================

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 Parameter SEL_W, default 3, select width; output width OUT_W = 2**SEL_W (derived, not overridable).
REQ-002 Parameter HOLD_W, default 4, width of dwell-count input.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en_n  input  1  active-low enable; 1 aborts activity and holds block idle.
REQ-006 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 in_valid  input  1  sel/hold request valid (direct mode).
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 sel  input  SEL_W  index to decode.
REQ-010 hold  input  HOLD_W  dwell in cycles; 0 treated as 1.
REQ-011 y  output  OUT_W  registered one-hot output, y[i] set for index i.
REQ-012 y_valid  output  1  high whenever y is non-zero.
REQ-013 scan_wrap  output  1  one-cycle pulse when scan wraps to index 0.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, SCAN; y SHALL be all-zero in IDLE.
REQ-015 in_ready SHALL be 1 iff en_n=0, mode=0, and (state=IDLE or (state=HOLD and dwell counter=0)).
REQ-016 Accept = in_valid & in_ready; on accept, next cycle y = 1<<sel, state HOLD, counter loaded with max(hold,1)-1 (latency 1 cycle).
REQ-017 y SHALL stay asserted exactly max(hold,1) cycles per accepted request; sel/hold sampled only at accept.
REQ-018 Accept in final HOLD cycle SHALL produce the new y with no zero gap (back-to-back).
REQ-019 HOLD with counter=0 and no accept SHALL return to IDLE; y=0 next cycle.
REQ-020 In IDLE with en_n=0 and mode=1, next cycle SHALL enter SCAN with y[0]=1, counter = max(hold,1)-1.
REQ-021 In SCAN, when counter=0, one-hot SHALL rotate to next index, hold resampled; OUT_W-1 wraps to 0 with scan_wrap=1 in that same cycle as y[0] reasserts.
REQ-022 mode 0->1 during HOLD SHALL let HOLD finish, then enter SCAN via IDLE rule; mode 1->0 during SCAN SHALL give y=0, IDLE next cycle.
REQ-023 en_n=1 in any state SHALL force y=0, y_valid=0, scan_wrap=0, state IDLE next cycle; in_ready=0 combinationally.
REQ-024 in_valid while in_ready=0 SHALL be ignored (not queued).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, y=0, y_valid=0, scan_wrap=0, counter=0.
REQ-026 Reset mid-HOLD or mid-SCAN SHALL discard the transaction; first accept after release behaves as from power-up.

Configuration
REQ-027 Macro DEC_SCAN_EN defined: SCAN state and scan_wrap behaviour per REQ-020..022.
REQ-028 DEC_SCAN_EN undefined: SCAN logic absent, mode ignored (treated as 0), scan_wrap tied 0, ports unchanged.

Structure
REQ-029 Package dec_pkg SHALL hold the state typedef (IDLE/HOLD/SCAN) and default constants for SEL_W and HOLD_W.
REQ-030 Dwell down-counter SHALL be a sub-module dec_hold_timer (load, decrement, zero flag), shared by HOLD and SCAN.

Verification (SEL_W=3, HOLD_W=4)
REQ-031 Direct: en_n=0, mode=0, sel=5, hold=3, one-cycle in_valid -> y=8'b0010_0000 for exactly 3 cycles starting 1 cycle after accept, then 0.
REQ-032 Back-to-back: sel=2 hold=2, then in_valid held with sel=6 hold=1 -> y 0x04,0x04,0x40 contiguous, in_ready high on 2nd 0x04 cycle.
REQ-033 hold=0: sel=0 -> y=0x01 for exactly 1 cycle.
REQ-034 Scan: mode=1, hold=1 -> y 0x01,0x02,...,0x80,0x01; scan_wrap=1 only with the second 0x01; with DEC_SCAN_EN undefined y stays 0.
REQ-035 Abort: en_n=1 mid-HOLD (sel=3 hold=8) -> y=0 next cycle, in_ready=0 same cycle.
REQ-036 Async reset: rst_n=0 mid-SCAN between clock edges -> y=0 immediately, no scan_wrap after release until a full scan cycle.

Source files
------------

// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the one-hot decoder block:
//   - dec_state_e : controller state encoding (IDLE / HOLD / SCAN)
//   - SEL_W_DEF   : default select width
//   - HOLD_W_DEF  : default dwell-count width
// -----------------------------------------------------------------------------
package dec_pkg;

  localparam int SEL_W_DEF  = 3;
  localparam int HOLD_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } dec_state_e;

endpackage : dec_pkg

// File: rtl/dec_hold_timer.sv
// -----------------------------------------------------------------------------
// dec_hold_timer
// Dwell down-counter shared by the HOLD and SCAN states of the decoder.
// Priority: clear > load > decrement. The count never goes below zero.
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, count -> 0
//   clear    : synchronous clear to 0
//   load     : load load_val
//   load_val : value loaded on load
//   dec      : decrement by one while non-zero
//   count    : current count
//   zero     : count == 0
// -----------------------------------------------------------------------------
module dec_hold_timer #(
  parameter int W = dec_pkg::HOLD_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: state is updated with non-blocking assignments inside an
  // always_ff that lists the asynchronous reset in its sensitivity list, so
  // every register settles on the same edge without ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule : dec_hold_timer

// File: rtl/onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq
// Registered one-hot decoder with a per-request dwell time and an optional
// auto-scan mode that walks the one-hot output across all indices.
//
// Configuration:
//   DEC_SCAN_EN : when defined, mode=1 enables the SCAN state and scan_wrap.
//                 When undefined, mode is ignored and scan_wrap is tied 0.
//
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   en_n      : active-low enable; high aborts and holds the block idle
//   mode      : 0 = direct decode, 1 = auto-scan
//   in_valid  : sel/hold request valid (direct mode)
//   in_ready  : request can be accepted this cycle (combinational)
//   sel       : index to decode
//   hold      : dwell in cycles, 0 treated as 1
//   y         : registered one-hot output
//   y_valid   : y is non-zero
//   scan_wrap : one-cycle pulse when the scan returns to index 0
// -----------------------------------------------------------------------------
module onehot_decoder_seq
  import dec_pkg::*;
#(
  parameter  int SEL_W  = SEL_W_DEF,
  parameter  int HOLD_W = HOLD_W_DEF,
  localparam int OUT_W  = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  sel,
  input  logic [HOLD_W-1:0] hold,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  output logic              scan_wrap
);

  dec_state_e        state, state_next;
  logic [OUT_W-1:0]  y_next;
  logic              wrap_next;

  logic              tmr_clear;
  logic              tmr_load;
  logic              tmr_dec;
  logic [HOLD_W-1:0] tmr_load_val;
  logic [HOLD_W-1:0] tmr_count;
  logic              tmr_zero;

  logic              mode_eff;
  logic              accept;
  logic [OUT_W-1:0]  sel_onehot;

`ifdef DEC_SCAN_EN
  assign mode_eff = mode;
`else
  // Scan support is compiled out; mode is deliberately left unused.
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = 1'b0;
`endif

  // A dwell of 0 behaves as 1, so the counter reload is max(hold,1)-1.
  assign tmr_load_val = (hold == '0) ? '0 : hold - 1'b1;

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  assign in_ready = !en_n && !mode_eff &&
                    ((state == IDLE) || ((state == HOLD) && tmr_zero));
  assign accept   = in_valid && in_ready;

  dec_hold_timer #(
    .W (HOLD_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal driven here is assigned a default first so that no
    // path through the case statement can leave one unassigned (no latches).
    state_next = state;
    y_next     = y;
    wrap_next  = 1'b0;
    tmr_clear  = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    if (en_n) begin
      state_next = IDLE;
      y_next     = '0;
      tmr_clear  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_next = HOLD;
            y_next     = sel_onehot;
            tmr_load   = 1'b1;
          end else if (mode_eff) begin
            state_next = SCAN;
            y_next     = {{(OUT_W-1){1'b0}}, 1'b1};
            tmr_load   = 1'b1;
          end
        end

        HOLD: begin
          if (accept) begin
            // Back-to-back request in the final dwell cycle: no zero gap.
            y_next   = sel_onehot;
            tmr_load = 1'b1;
          end else if (tmr_zero) begin
            state_next = IDLE;
            y_next     = '0;
          end else begin
            tmr_dec = 1'b1;
          end
        end

        SCAN: begin
`ifdef DEC_SCAN_EN
          if (!mode_eff) begin
            state_next = IDLE;
            y_next     = '0;
            tmr_clear  = 1'b1;
          end else if (tmr_zero) begin
            // Rotate left; the top bit falling back to bit 0 is the wrap.
            y_next    = {y[OUT_W-2:0], y[OUT_W-1]};
            wrap_next = y[OUT_W-1];
            tmr_load  = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
`else
          state_next = IDLE;
          y_next     = '0;
          tmr_clear  = 1'b1;
`endif
        end

        default: begin
          state_next = IDLE;
          y_next     = '0;
          tmr_clear  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      scan_wrap <= 1'b0;
    end else begin
      state     <= state_next;
      y         <= y_next;
`ifdef DEC_SCAN_EN
      scan_wrap <= wrap_next;
`else
      scan_wrap <= 1'b0;
`endif
    end
  end

  assign y_valid = |y;

endmodule : onehot_decoder_seq
